// File: rtl/axil_perip_bridge_if.sv
// AXI4-Lite slave channels plus the simple peripheral bus, bundled for the bridge.
// slave = bridge side; master = CPU datapath and peripheral side.
interface axil_perip_bridge_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_awvalid;
  logic              s_awready;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;
  logic [ADDR_W-1:0] perip_addr;
  logic              perip_wen;
  logic              perip_ren;
  logic [1:0]        perip_mask;
  logic [31:0]       perip_wdata;
  logic [31:0]       perip_rdata;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_araddr, s_arvalid, s_rready, perip_rdata,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready,
    output s_rdata, s_rresp, s_rvalid,
    output perip_addr, perip_wen, perip_ren, perip_mask, perip_wdata
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_araddr, s_arvalid, s_rready, perip_rdata,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready,
    input  s_rdata, s_rresp, s_rvalid,
    input  perip_addr, perip_wen, perip_ren, perip_mask, perip_wdata
  );
endinterface

// File: rtl/axil_perip_bridge.sv
// AXI4-Lite slave to peripheral bridge: writes take 2 cycles to bvalid, reads READ_LATENCY+1 to rvalid.
// One transaction at a time; responses hold until accepted, readies drop outside IDLE.
module axil_perip_bridge #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  axil_perip_bridge_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_ISSUE, WR_RESP} state_e;

  localparam logic [3:0] CNT_LAST = 4'(READ_LATENCY - 1);

  state_e            state_q;
  logic              aw_held_q, w_held_q;
  logic              last_op_q;  // 1 = write served last
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] perip_addr_q;
  logic              perip_wen_q, perip_ren_q;
  logic [1:0]        perip_mask_q;
  logic [DATA_W-1:0] perip_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q, bvalid_q;
  logic [1:0]        bresp_q;

  logic              is_idle, rd_grant, awready, wready, arready;
  logic              aw_hs, w_hs, ar_hs, wr_go;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [3:0]        wr_strb;
  logic              strb_legal;
  logic [1:0]        strb_mask, strb_lo;

  assign is_idle  = (state_q == IDLE);
  assign rd_grant = is_idle & !aw_held_q & !w_held_q & bus.s_arvalid &
                    (!(bus.s_awvalid | bus.s_wvalid) | last_op_q);
  assign awready  = is_idle & !aw_held_q & !rd_grant;
  assign wready   = is_idle & !w_held_q & !rd_grant;
  assign arready  = is_idle & !aw_held_q & !w_held_q & rd_grant;

  assign aw_hs = bus.s_awvalid & awready;
  assign w_hs  = bus.s_wvalid & wready;
  assign ar_hs = bus.s_arvalid & arready;
  assign wr_go = (aw_held_q | aw_hs) & (w_held_q | w_hs);

  // The half completing this cycle is taken straight from the bus.
  assign wr_addr = aw_held_q ? awaddr_q : bus.s_awaddr;
  assign wr_data = w_held_q ? wdata_q : bus.s_wdata;
  assign wr_strb = w_held_q ? wstrb_q : bus.s_wstrb;

  always_comb begin
    strb_legal = 1'b1;
    strb_mask  = 2'b00;
    strb_lo    = 2'b00;
    case (wr_strb)
      4'b0001: strb_lo = 2'd0;
      4'b0010: strb_lo = 2'd1;
      4'b0100: strb_lo = 2'd2;
      4'b1000: strb_lo = 2'd3;
      4'b0011: strb_mask = 2'b01;
      4'b1100: begin strb_mask = 2'b01; strb_lo = 2'd2; end
      4'b1111: strb_mask = 2'b10;
      default: begin strb_legal = 1'b0; strb_mask = 2'b11; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      aw_held_q     <= 1'b0;
      w_held_q      <= 1'b0;
      last_op_q     <= 1'b1;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      cnt_q         <= '0;
      perip_addr_q  <= '0;
      perip_wen_q   <= 1'b0;
      perip_ren_q   <= 1'b0;
      perip_mask_q  <= 2'b11;
      perip_wdata_q <= '0;
      rdata_q       <= '0;
      rvalid_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      bresp_q       <= 2'b00;
    end else begin
      perip_wen_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (aw_hs) begin
            aw_held_q <= 1'b1;
            awaddr_q  <= bus.s_awaddr;
          end
          if (w_hs) begin
            w_held_q <= 1'b1;
            wdata_q  <= bus.s_wdata;
            wstrb_q  <= bus.s_wstrb;
          end
          if (wr_go) begin
            state_q       <= WR_ISSUE;
            last_op_q     <= 1'b1;
            perip_addr_q  <= {wr_addr[ADDR_W-1:2], strb_lo};
            perip_wdata_q <= wr_data;
            perip_wen_q   <= strb_legal;
            perip_mask_q  <= strb_mask;
            bresp_q       <= strb_legal ? 2'b00 : 2'b10;
          end else if (ar_hs) begin
            state_q      <= RD_WAIT;
            last_op_q    <= 1'b0;
            perip_addr_q <= bus.s_araddr;
            perip_ren_q  <= 1'b1;
            cnt_q        <= '0;
          end
        end
        RD_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            rdata_q     <= bus.perip_rdata;
            perip_ren_q <= 1'b0;
            rvalid_q    <= 1'b1;
            state_q     <= RD_RESP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        RD_RESP: begin
          if (bus.s_rready) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        WR_ISSUE: begin
          perip_mask_q <= 2'b11;
          bvalid_q     <= 1'b1;
          state_q      <= WR_RESP;
        end
        WR_RESP: begin
          if (bus.s_bready) begin
            bvalid_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_awready   = awready;
  assign bus.s_wready    = wready;
  assign bus.s_arready   = arready;
  assign bus.s_bvalid    = bvalid_q;
  assign bus.s_bresp     = bresp_q;
  assign bus.s_rvalid    = rvalid_q;
  assign bus.s_rdata     = rdata_q;
  assign bus.s_rresp     = 2'b00;
  assign bus.perip_addr  = perip_addr_q;
  assign bus.perip_wen   = perip_wen_q;
  assign bus.perip_ren   = perip_ren_q;
  assign bus.perip_mask  = perip_mask_q;
  assign bus.perip_wdata = perip_wdata_q;
endmodule

// File: tb/tb_axil_perip_bridge.sv
// Directed bench: three bridges (READ_LATENCY 1, 2, 5) share stimulus; index 1 is the main DUT.
// A small peripheral model drives 0x1234_5678 only on each DUT's final read cycle.
module tb_axil_perip_bridge;
  localparam int M = 1;

  logic        clk;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;

  logic        awready_a [3];
  logic        wready_a  [3];
  logic        arready_a [3];
  logic        bvalid_a  [3];
  logic [1:0]  bresp_a   [3];
  logic        rvalid_a  [3];
  logic [31:0] rdata_a   [3];
  logic [1:0]  rresp_a   [3];
  logic [31:0] paddr_a   [3];
  logic        wen_a     [3];
  logic        ren_a     [3];
  logic [1:0]  mask_a    [3];
  logic [31:0] pwdata_a  [3];

  int errors = 0;
  int checks = 0;
  int lats [3] = '{1, 2, 5};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 5);
    axil_perip_bridge_if #(.ADDR_W(32)) bus ();
    logic [3:0] rcnt;

    assign bus.s_awaddr    = awaddr;
    assign bus.s_awvalid   = awvalid;
    assign bus.s_wdata     = wdata;
    assign bus.s_wstrb     = wstrb;
    assign bus.s_wvalid    = wvalid;
    assign bus.s_bready    = bready;
    assign bus.s_araddr    = araddr;
    assign bus.s_arvalid   = arvalid;
    assign bus.s_rready    = rready;
    assign bus.perip_rdata = (bus.perip_ren && rcnt == 4'(L - 1)) ? 32'h1234_5678 : 32'hBAD0_BAD0;

    always @(posedge clk) rcnt <= bus.perip_ren ? rcnt + 4'd1 : 4'd0;

    assign awready_a[g] = bus.s_awready;
    assign wready_a[g]  = bus.s_wready;
    assign arready_a[g] = bus.s_arready;
    assign bvalid_a[g]  = bus.s_bvalid;
    assign bresp_a[g]   = bus.s_bresp;
    assign rvalid_a[g]  = bus.s_rvalid;
    assign rdata_a[g]   = bus.s_rdata;
    assign rresp_a[g]   = bus.s_rresp;
    assign paddr_a[g]   = bus.perip_addr;
    assign wen_a[g]     = bus.perip_wen;
    assign ren_a[g]     = bus.perip_ren;
    assign mask_a[g]    = bus.perip_mask;
    assign pwdata_a[g]  = bus.perip_wdata;

    axil_perip_bridge #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(L)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    awaddr = '0; wdata = '0; araddr = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    checks++; if (bvalid_a[M] !== 1'b0) begin errors++; $display("FAIL rst_bvalid got %b want 0", bvalid_a[M]); end
    checks++; if (rvalid_a[M] !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b want 0", rvalid_a[M]); end
    checks++; if (wen_a[M] !== 1'b0) begin errors++; $display("FAIL rst_wen got %b want 0", wen_a[M]); end
    checks++; if (ren_a[M] !== 1'b0) begin errors++; $display("FAIL rst_ren got %b want 0", ren_a[M]); end
    checks++; if (rdata_a[M] !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", rdata_a[M]); end
    checks++; if (bresp_a[M] !== 2'b00) begin errors++; $display("FAIL rst_bresp got %b want 00", bresp_a[M]); end
    checks++; if (rresp_a[M] !== 2'b00) begin errors++; $display("FAIL rst_rresp got %b want 00", rresp_a[M]); end
    checks++; if (paddr_a[M] !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", paddr_a[M]); end
    checks++; if (mask_a[M] !== 2'b11) begin errors++; $display("FAIL rst_mask got %b want 11", mask_a[M]); end
    checks++; if (awready_a[M] !== 1'b1) begin errors++; $display("FAIL rst_awready got %b want 1", awready_a[M]); end
    checks++; if (wready_a[M] !== 1'b1) begin errors++; $display("FAIL rst_wready got %b want 1", wready_a[M]); end
    checks++; if (arready_a[M] !== 1'b0) begin errors++; $display("FAIL rst_arready_idle got %b want 0", arready_a[M]); end
    arvalid = 1'b1;
    #1;
    checks++; if (arready_a[M] !== 1'b1) begin errors++; $display("FAIL rst_arready_ar got %b want 1", arready_a[M]); end
    checks++; if (awready_a[M] !== 1'b0) begin errors++; $display("FAIL rst_awready_ar got %b want 0", awready_a[M]); end
    arvalid = 1'b0;
    #1;
  endtask

  task automatic test_read_latency();
    araddr = 32'h20; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (ren_a[g] !== (k <= lats[g])) begin
          errors++; $display("FAIL lat%0d_ren cyc%0d got %b want %b", lats[g], k, ren_a[g], (k <= lats[g]));
        end
        checks++;
        if (rvalid_a[g] !== (k >= lats[g] + 1 && k <= 9)) begin
          errors++; $display("FAIL lat%0d_rvalid cyc%0d got %b want %b", lats[g], k, rvalid_a[g], (k >= lats[g] + 1 && k <= 9));
        end
        if (k <= lats[g]) begin
          checks++;
          if (paddr_a[g] !== 32'h20) begin errors++; $display("FAIL lat%0d_addr cyc%0d got %h want 20", lats[g], k, paddr_a[g]); end
        end else begin
          checks++;
          if (rdata_a[g] !== 32'h1234_5678) begin errors++; $display("FAIL lat%0d_rdata cyc%0d got %h want 12345678", lats[g], k, rdata_a[g]); end
          checks++;
          if (rresp_a[g] !== 2'b00) begin errors++; $display("FAIL lat%0d_rresp cyc%0d got %b want 00", lats[g], k, rresp_a[g]); end
        end
      end
      rready = (k == 9);
      tick();
    end
    rready = 1'b0;
  endtask

  task automatic test_write_word();
    awaddr = 32'h8000_0104; wdata = 32'hDEAD_BEEF; wstrb = 4'b1111;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    #1;
    checks++; if (awready_a[M] !== 1'b1 || wready_a[M] !== 1'b1) begin errors++; $display("FAIL ww_ready got aw=%b w=%b want 1/1", awready_a[M], wready_a[M]); end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++; if (wen_a[M] !== 1'b1) begin errors++; $display("FAIL ww_wen got %b want 1", wen_a[M]); end
    checks++; if (paddr_a[M] !== 32'h8000_0104) begin errors++; $display("FAIL ww_addr got %h want 80000104", paddr_a[M]); end
    checks++; if (mask_a[M] !== 2'b10) begin errors++; $display("FAIL ww_mask got %b want 10", mask_a[M]); end
    checks++; if (pwdata_a[M] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ww_wdata got %h want deadbeef", pwdata_a[M]); end
    checks++; if (awready_a[M] !== 1'b0) begin errors++; $display("FAIL ww_awready_busy got %b want 0", awready_a[M]); end
    tick();
    checks++; if (wen_a[M] !== 1'b0) begin errors++; $display("FAIL ww_wen_once got %b want 0", wen_a[M]); end
    checks++; if (mask_a[M] !== 2'b11) begin errors++; $display("FAIL ww_mask_after got %b want 11", mask_a[M]); end
    checks++; if (bvalid_a[M] !== 1'b1 || bresp_a[M] !== 2'b00) begin errors++; $display("FAIL ww_b got v=%b r=%b want 1/00", bvalid_a[M], bresp_a[M]); end
    tick();
    checks++; if (bvalid_a[M] !== 1'b1) begin errors++; $display("FAIL ww_bhold got %b want 1", bvalid_a[M]); end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++; if (bvalid_a[M] !== 1'b0) begin errors++; $display("FAIL ww_bdone got %b want 0", bvalid_a[M]); end
    checks++; if (awready_a[M] !== 1'b1) begin errors++; $display("FAIL ww_idle got %b want 1", awready_a[M]); end
  endtask

  task automatic test_w_before_aw();
    wdata = 32'hCAFE_F00D; wstrb = 4'b0100; wvalid = 1'b1; bready = 1'b1;
    #1;
    checks++; if (wready_a[M] !== 1'b1) begin errors++; $display("FAIL wa_wready got %b want 1", wready_a[M]); end
    tick();
    wvalid = 1'b0; araddr = 32'h99; arvalid = 1'b1;
    #1;
    checks++; if (arready_a[M] !== 1'b0) begin errors++; $display("FAIL wa_rd_blocked got %b want 0", arready_a[M]); end
    checks++; if (awready_a[M] !== 1'b1 || wready_a[M] !== 1'b0) begin errors++; $display("FAIL wa_half got aw=%b w=%b want 1/0", awready_a[M], wready_a[M]); end
    checks++; if (wen_a[M] !== 1'b0) begin errors++; $display("FAIL wa_early_wen got %b want 0", wen_a[M]); end
    tick();
    tick();
    arvalid = 1'b0; awaddr = 32'h10; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    checks++; if (wen_a[M] !== 1'b1) begin errors++; $display("FAIL wa_wen got %b want 1", wen_a[M]); end
    checks++; if (paddr_a[M] !== 32'h12) begin errors++; $display("FAIL wa_addr got %h want 12", paddr_a[M]); end
    checks++; if (mask_a[M] !== 2'b00) begin errors++; $display("FAIL wa_mask got %b want 00", mask_a[M]); end
    checks++; if (pwdata_a[M] !== 32'hCAFE_F00D) begin errors++; $display("FAIL wa_wdata got %h want cafef00d", pwdata_a[M]); end
    tick();
    checks++; if (wen_a[M] !== 1'b0) begin errors++; $display("FAIL wa_wen_once got %b want 0", wen_a[M]); end
    checks++; if (bvalid_a[M] !== 1'b1 || bresp_a[M] !== 2'b00) begin errors++; $display("FAIL wa_b got v=%b r=%b want 1/00", bvalid_a[M], bresp_a[M]); end
    tick();
    checks++; if (bvalid_a[M] !== 1'b0) begin errors++; $display("FAIL wa_bdone got %b want 0", bvalid_a[M]); end
    bready = 1'b0;
  endtask

  task automatic test_bad_strobe();
    awaddr = 32'h30; wdata = 32'h1111_2222; wstrb = 4'b0110;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++; if (wen_a[M] !== 1'b0) begin errors++; $display("FAIL bs_wen got %b want 0", wen_a[M]); end
    checks++; if (mask_a[M] !== 2'b11) begin errors++; $display("FAIL bs_mask got %b want 11", mask_a[M]); end
    tick();
    checks++; if (wen_a[M] !== 1'b0) begin errors++; $display("FAIL bs_wen2 got %b want 0", wen_a[M]); end
    checks++; if (bvalid_a[M] !== 1'b1 || bresp_a[M] !== 2'b10) begin errors++; $display("FAIL bs_b got v=%b r=%b want 1/10", bvalid_a[M], bresp_a[M]); end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++; if (bvalid_a[M] !== 1'b0) begin errors++; $display("FAIL bs_bdone got %b want 0", bvalid_a[M]); end
  endtask

  task automatic test_back_to_back();
    araddr = 32'h40; arvalid = 1'b1;
    awaddr = 32'h44; awvalid = 1'b1; wdata = 32'h55AA_55AA; wstrb = 4'b1111; wvalid = 1'b1;
    rready = 1'b1; bready = 1'b1;
    #1;
    checks++; if (arready_a[M] !== 1'b1 || awready_a[M] !== 1'b0 || wready_a[M] !== 1'b0) begin
      errors++; $display("FAIL bb_tie1 got ar=%b aw=%b w=%b want 1/0/0", arready_a[M], awready_a[M], wready_a[M]);
    end
    tick();
    arvalid = 1'b0;
    checks++; if (ren_a[M] !== 1'b1 || paddr_a[M] !== 32'h40) begin errors++; $display("FAIL bb_rd1 got ren=%b addr=%h want 1/40", ren_a[M], paddr_a[M]); end
    checks++; if (wen_a[M] !== 1'b0) begin errors++; $display("FAIL bb_rd1_wen got %b want 0", wen_a[M]); end
    tick();
    tick();
    checks++; if (rvalid_a[M] !== 1'b1 || rdata_a[M] !== 32'h1234_5678) begin errors++; $display("FAIL bb_r1 got v=%b d=%h want 1/12345678", rvalid_a[M], rdata_a[M]); end
    tick();
    araddr = 32'h48; arvalid = 1'b1;
    #1;
    checks++; if (arready_a[M] !== 1'b0 || awready_a[M] !== 1'b1 || wready_a[M] !== 1'b1) begin
      errors++; $display("FAIL bb_tie2 got ar=%b aw=%b w=%b want 0/1/1", arready_a[M], awready_a[M], wready_a[M]);
    end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++; if (wen_a[M] !== 1'b1 || paddr_a[M] !== 32'h44 || mask_a[M] !== 2'b10) begin
      errors++; $display("FAIL bb_wr got wen=%b addr=%h mask=%b want 1/44/10", wen_a[M], paddr_a[M], mask_a[M]);
    end
    tick();
    checks++; if (bvalid_a[M] !== 1'b1) begin errors++; $display("FAIL bb_b got %b want 1", bvalid_a[M]); end
    tick();
    checks++; if (arready_a[M] !== 1'b1) begin errors++; $display("FAIL bb_rd2_ready got %b want 1", arready_a[M]); end
    tick();
    arvalid = 1'b0;
    checks++; if (ren_a[M] !== 1'b1 || paddr_a[M] !== 32'h48) begin errors++; $display("FAIL bb_rd2 got ren=%b addr=%h want 1/48", ren_a[M], paddr_a[M]); end
    repeat (3) tick();
    checks++; if (rvalid_a[M] !== 1'b0 || awready_a[M] !== 1'b1) begin errors++; $display("FAIL bb_end got rv=%b aw=%b want 0/1", rvalid_a[M], awready_a[M]); end
    rready = 1'b0; bready = 1'b0;
  endtask

  task automatic test_reset_mid();
    araddr = 32'h60; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    checks++; if (ren_a[M] !== 1'b1) begin errors++; $display("FAIL rm_rd_pre got %b want 1", ren_a[M]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (ren_a[M] !== 1'b0 || rvalid_a[M] !== 1'b0) begin errors++; $display("FAIL rm_rd got ren=%b rv=%b want 0/0", ren_a[M], rvalid_a[M]); end
    checks++; if (mask_a[M] !== 2'b11 || awready_a[M] !== 1'b1) begin errors++; $display("FAIL rm_rd_idle got mask=%b aw=%b want 11/1", mask_a[M], awready_a[M]); end
    repeat (3) tick();
    checks++; if (rvalid_a[M] !== 1'b0) begin errors++; $display("FAIL rm_rd_noresp got %b want 0", rvalid_a[M]); end

    awaddr = 32'h70; wdata = 32'h1; wstrb = 4'b1111; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    checks++; if (bvalid_a[M] !== 1'b1) begin errors++; $display("FAIL rm_wr_pre got %b want 1", bvalid_a[M]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bvalid_a[M] !== 1'b0 || wen_a[M] !== 1'b0 || ren_a[M] !== 1'b0) begin
      errors++; $display("FAIL rm_wr got bv=%b wen=%b ren=%b want 0/0/0", bvalid_a[M], wen_a[M], ren_a[M]);
    end
    checks++; if (mask_a[M] !== 2'b11 || awready_a[M] !== 1'b1 || wready_a[M] !== 1'b1) begin
      errors++; $display("FAIL rm_wr_idle got mask=%b aw=%b w=%b want 11/1/1", mask_a[M], awready_a[M], wready_a[M]);
    end
    tick();
    checks++; if (bvalid_a[M] !== 1'b0) begin errors++; $display("FAIL rm_wr_noresp got %b want 0", bvalid_a[M]); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not reach summary");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_read_latency();
    test_write_word();
    test_w_before_aw();
    test_bad_strobe();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
